ram_responder: RTL and testbench
================================

# ram_responder

RAM-side responder for the memory controller's single-ported RAM bus. It accepts `ramREN`/`ramWEN` requests, serves them from a word array after a programmable latency, and reports progress on `ramstate`. It sits below `memory_control`, which advances its states only on `ACCESS`. It also keeps saturating read and write access counters for bus-traffic statistics.

## Interface
Parameters:
- `LAT`, 2: number of `BUSY` cycles before `ACCESS`; legal range 0–15.
- `DEPTH`, 1024: array size in 32-bit words; byte addresses `0 .. 4*DEPTH-1` are legal.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `nRST`  in  1  reset; **synchronous, active-high** (asserted = 1, sampled on the `CLK` rising edge).
- `ramREN`  in  1  read request; held until `ACCESS` is seen.
- `ramWEN`  in  1  write request; held until `ACCESS` is seen.
- `ramaddr`  in  32  byte address; bits [1:0] are ignored.
- `ramstore`  in  32  write data.
- `ramload`  out  32  read data.
- `ramstate`  out  `ramstate_t` (`cpu_types_pkg`)  one of `FREE`, `BUSY`, `ACCESS`, `ERROR`.
- `rd_count`  out  32  completed reads; saturates at `32'hFFFF_FFFF`.
- `wr_count`  out  32  completed writes; saturates at `32'hFFFF_FFFF`.

## Operation
- Registered state:
  - `cnt` (4 bits)
  - `req_addr` (word index)
  - `req_op` (0 = read, 1 = write)
  - `active` (a request was in progress last cycle and did not complete)
  - the word array
  - both counters
- **Request** = `ramREN ^ ramWEN`.
- **Continuation**: a request continues when `active` = 1 and `ramaddr[31:2]` = `req_addr` and the op equals `req_op`. Any other request starts at `cnt` = 0 and latches its address and op.
- **`ramstate`** (combinational):
  - `ERROR` if `ramREN & ramWEN`, or if a request targets an address ≥ `4*DEPTH`.
  - Else `FREE` if there is no request.
  - Else `ACCESS` if the effective count (0 for a new request, `cnt` for a continuation) equals `LAT`.
  - Else `BUSY`.
- **Cycle after a `BUSY` cycle**: `cnt` increments and `active` = 1.
- **Cycle after an `ACCESS` cycle**:
  - `cnt` ← 0 and `active` ← 0.
  - A request still held after `ACCESS` is therefore treated as a new access: identical address and op get a full `LAT` delay again. This is how back-to-back `STORE_1`/`STORE_2` transfers are served.
- **`FREE` or `ERROR` cycle**: `active` ← 0 and `cnt` ← 0.
- **Read in an `ACCESS` cycle**: `ramload` = `mem[ramaddr[31:2]]`, combinational. `ramload` = 0 in every other cycle.
- **Write in an `ACCESS` cycle**: `mem[ramaddr[31:2]]` ← `ramstore` at the closing edge.
  - A read issued in the next cycle to the same word returns the new data.
  - No write occurs in `BUSY`, `ERROR`, or `FREE`.
- **Counters**: `rd_count` increments on each read `ACCESS`, `wr_count` on each write `ACCESS`. Both saturate.
- **Request change mid-count** (address, op, or deassertion): the in-flight access is abandoned, with no write and no count. A changed request restarts at `cnt` = 0.

## Timing
- **Reset** (`nRST` = 1 at an edge):
  - Next cycle: `cnt` = 0, `active` = 0, `rd_count` = `wr_count` = 0, every array word = 0.
  - While `nRST` is high, outputs are forced: `ramstate` = `FREE`, `ramload` = 0, no writes or counts. This applies even to a request arriving mid-count.
- **Latency**: a request first presented in cycle *t*, held steady, shows `BUSY` in cycles *t .. t+LAT-1* and `ACCESS` in cycle *t+LAT*.
- **`LAT` = 0**: `ACCESS` in the first cycle of every request, including back-to-back held requests (one access per cycle).
- **Throughput**: one access per `LAT+1` cycles per continuously held requester.
- **`ERROR`**: holds as long as the offending inputs are held. Clearing them returns `ramstate` to `FREE`, or to a fresh `BUSY`, in the same cycle.
- **Address wrap**: none. Out-of-range addresses produce `ERROR` and never alias.

## Test plan
- **Reset then read**:
  - Stimulus: reset; `ramREN` = 1, `ramaddr` = `0x40`, `LAT` = 2.
  - Required: `BUSY`, `BUSY`, then `ACCESS` with `ramload` = 0; `rd_count` = 1.
- **Write then read back**:
  - Stimulus: write `0xDEADBEEF` to `0x100`, hold until `ACCESS`; next cycle read `0x100`.
  - Required: `ACCESS` on the 3rd cycle of the read, with `ramload` = `0xDEADBEEF`; `wr_count` = 1, `rd_count` = 1.
- **Back-to-back held write**:
  - Stimulus: `ramWEN` held, address changes `0x0` → `0x4` the cycle after `ACCESS`.
  - Required: two `ACCESS` pulses 3 cycles apart; `mem[0]` and `mem[1]` updated; `wr_count` = 2.
- **Abandon**:
  - Stimulus: write to `0x8` with `ramstore` = `0x55`; the address switches to `0xC` after 1 `BUSY` cycle.
  - Required: `mem[2]` unchanged; `0xC` completes 3 cycles after the switch.
- **Errors**:
  - Stimulus 1: `ramREN` = `ramWEN` = 1. Required: `ERROR`, no count change.
  - Stimulus 2: `ramaddr` = `4*DEPTH` with `ramREN` = 1. Required: `ERROR`, no count change.
  - Stimulus 3: drop `ramWEN` from the first case. Required: a fresh read completes in `LAT+1` cycles.
- **Reset mid-operation**:
  - Stimulus: assert `nRST` during the 2nd `BUSY` cycle of a write of `0x77` to `0x20`.
  - Required: `ramstate` = `FREE` while reset is held; `mem[8]` = 0; after release the held request restarts with a full `LAT`.

Source files
------------

// File: rtl/ram_responder_if.sv
// Shared RAM bus state type and the RAM-side bus interface.
// The controller drives requests; the responder answers with state and data.
package cpu_types_pkg;
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;
endpackage

interface ram_responder_if;
   import cpu_types_pkg::*;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   ramstate_t   ramstate;
   logic [31:0] rd_count;
   logic [31:0] wr_count;

   modport master (
      output ramREN, ramWEN, ramaddr, ramstore,
      input  ramload, ramstate, rd_count, wr_count
   );
   modport slave (
      input  ramREN, ramWEN, ramaddr, ramstore,
      output ramload, ramstate, rd_count, wr_count
   );
endinterface

// File: rtl/ram_responder.sv
// RAM-side responder: word array served after LAT busy cycles,
// with saturating read/write access counters.
module ram_responder
   import cpu_types_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 1024
) (
   input  logic            CLK,
   input  logic            nRST,
   ram_responder_if.slave  bus
);
   localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LAT4 = LAT[3:0];

   logic [31:0] r_mem [DEPTH];
   logic [3:0]  r_cnt;
   logic [29:0] r_addr;
   logic        r_op;
   logic        r_active;
   logic [31:0] r_rd;
   logic [31:0] r_wr;

   logic          w_req;
   logic          w_inrange;
   logic          w_cont;
   logic [3:0]    w_eff;
   logic [AW-1:0] w_idx;
   ramstate_t     w_state;
   logic          w_acc_rd;
   logic          w_acc_wr;

   assign w_req     = bus.ramREN ^ bus.ramWEN;
   assign w_idx     = bus.ramaddr[AW+1:2];
   assign w_inrange = {2'b00, bus.ramaddr[31:2]} < 32'(DEPTH);
   assign w_cont    = r_active
                    && (bus.ramaddr[31:2] == r_addr)
                    && (bus.ramWEN == r_op);
   assign w_eff     = w_cont ? r_cnt : 4'd0;

   // Bus state decode; reset forces FREE so nothing completes
   always_comb begin
      w_state = FREE;
      if (!nRST) begin
         if (bus.ramREN && bus.ramWEN)
            w_state = ERROR;
         else if (w_req && !w_inrange)
            w_state = ERROR;
         else if (w_req && (w_eff == LAT4))
            w_state = ACCESS;
         else if (w_req)
            w_state = BUSY;
      end
   end

   assign w_acc_rd = (w_state == ACCESS) && bus.ramREN;
   assign w_acc_wr = (w_state == ACCESS) && bus.ramWEN;

   assign bus.ramstate = w_state;
   assign bus.ramload  = w_acc_rd ? r_mem[w_idx] : 32'd0;
   assign bus.rd_count = r_rd;
   assign bus.wr_count = r_wr;

   // Latency tracking: only a BUSY cycle carries the request forward
   always_ff @(posedge CLK) begin
      if (nRST) begin
         r_cnt    <= 4'd0;
         r_active <= 1'b0;
         r_addr   <= 30'd0;
         r_op     <= 1'b0;
      end else if (w_state == BUSY) begin
         r_cnt    <= w_eff + 4'd1;
         r_active <= 1'b1;
         r_addr   <= bus.ramaddr[31:2];
         r_op     <= bus.ramWEN;
      end else begin
         r_cnt    <= 4'd0;
         r_active <= 1'b0;
      end
   end

   // Word array: cleared on reset, written only in a write ACCESS
   always_ff @(posedge CLK) begin
      if (nRST) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= 32'd0;
      end else if (w_acc_wr) begin
         r_mem[w_idx] <= bus.ramstore;
      end
   end

   // Saturating traffic counters
   always_ff @(posedge CLK) begin
      if (nRST) begin
         r_rd <= 32'd0;
         r_wr <= 32'd0;
      end else begin
         if (w_acc_rd && (r_rd != 32'hFFFF_FFFF))
            r_rd <= r_rd + 32'd1;
         if (w_acc_wr && (r_wr != 32'hFFFF_FFFF))
            r_wr <= r_wr + 32'd1;
      end
   end
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed cycle vectors feed a scoreboard
// queue; a monitor on the falling edge pops and compares each cycle.
module tb_ram_responder;
   import cpu_types_pkg::*;

   typedef struct {
      ramstate_t   st;
      logic [31:0] ld;
      logic [31:0] rd;
      logic [31:0] wr;
      string       nm;
   } exp_t;

   logic CLK;
   logic nRST;
   exp_t q[$];
   int   checks;
   int   errors;

   ram_responder_if bus ();

   ram_responder #(.LAT(2), .DEPTH(1024)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step(
      input logic        rst,
      input logic        ren,
      input logic        wen,
      input logic [31:0] a,
      input logic [31:0] d,
      input ramstate_t   st,
      input logic [31:0] ld,
      input logic [31:0] rd,
      input logic [31:0] wr,
      input string       nm
   );
      exp_t e;
      @(posedge CLK);
      #1;
      nRST         = rst;
      bus.ramREN   = ren;
      bus.ramWEN   = wen;
      bus.ramaddr  = a;
      bus.ramstore = d;
      e.st = st; e.ld = ld; e.rd = rd; e.wr = wr; e.nm = nm;
      q.push_back(e);
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.ramstate !== e.st) begin
               errors++;
               $display("FAIL %s state got %0d want %0d",
                        e.nm, bus.ramstate, e.st);
            end
            checks++;
            if (bus.ramload !== e.ld) begin
               errors++;
               $display("FAIL %s ramload got %h want %h",
                        e.nm, bus.ramload, e.ld);
            end
            checks++;
            if (bus.rd_count !== e.rd) begin
               errors++;
               $display("FAIL %s rd_count got %0d want %0d",
                        e.nm, bus.rd_count, e.rd);
            end
            checks++;
            if (bus.wr_count !== e.wr) begin
               errors++;
               $display("FAIL %s wr_count got %0d want %0d",
                        e.nm, bus.wr_count, e.wr);
            end
         end
      end
   end

   initial begin
      int n;
      checks = 0;
      errors = 0;
      nRST = 1'b1;
      bus.ramREN = 1'b0;
      bus.ramWEN = 1'b0;
      bus.ramaddr = 32'd0;
      bus.ramstore = 32'd0;
      repeat (2) @(posedge CLK);

      // reset state, request ignored while reset held
      step(1, 1, 0, 32'h40, 0, FREE, 0, 0, 0, "rst");
      // reset then read 0x40
      step(0, 1, 0, 32'h40, 0, BUSY,   0, 0, 0, "rd40_b1");
      step(0, 1, 0, 32'h40, 0, BUSY,   0, 0, 0, "rd40_b2");
      step(0, 1, 0, 32'h40, 0, ACCESS, 0, 0, 0, "rd40_a");
      step(0, 0, 0, 32'h0,  0, FREE,   0, 1, 0, "idle1");
      // write then read back
      step(0, 0, 1, 32'h100, 32'hDEADBEEF, BUSY,   0, 1, 0, "wr100_b1");
      step(0, 0, 1, 32'h100, 32'hDEADBEEF, BUSY,   0, 1, 0, "wr100_b2");
      step(0, 0, 1, 32'h100, 32'hDEADBEEF, ACCESS, 0, 1, 0, "wr100_a");
      step(0, 1, 0, 32'h100, 0, BUSY,   0, 1, 1, "rd100_b1");
      step(0, 1, 0, 32'h100, 0, BUSY,   0, 1, 1, "rd100_b2");
      step(0, 1, 0, 32'h100, 0, ACCESS, 32'hDEADBEEF, 1, 1, "rd100_a");
      step(0, 0, 0, 32'h0,   0, FREE,   0, 2, 1, "idle2");
      // back-to-back held write, 0x0 then 0x4
      step(0, 0, 1, 32'h0, 32'h11111111, BUSY,   0, 2, 1, "bb0_b1");
      step(0, 0, 1, 32'h0, 32'h11111111, BUSY,   0, 2, 1, "bb0_b2");
      step(0, 0, 1, 32'h0, 32'h11111111, ACCESS, 0, 2, 1, "bb0_a");
      step(0, 0, 1, 32'h4, 32'h22222222, BUSY,   0, 2, 2, "bb4_b1");
      step(0, 0, 1, 32'h4, 32'h22222222, BUSY,   0, 2, 2, "bb4_b2");
      step(0, 0, 1, 32'h4, 32'h22222222, ACCESS, 0, 2, 2, "bb4_a");
      step(0, 0, 0, 32'h0, 0, FREE, 0, 2, 3, "idle3");
      // read back 0x0, then hold 0x4 for two full accesses
      step(0, 1, 0, 32'h0, 0, BUSY,   0, 2, 3, "rd0_b1");
      step(0, 1, 0, 32'h0, 0, BUSY,   0, 2, 3, "rd0_b2");
      step(0, 1, 0, 32'h0, 0, ACCESS, 32'h11111111, 2, 3, "rd0_a");
      step(0, 1, 0, 32'h4, 0, BUSY,   0, 3, 3, "rd4_b1");
      step(0, 1, 0, 32'h4, 0, BUSY,   0, 3, 3, "rd4_b2");
      step(0, 1, 0, 32'h4, 0, ACCESS, 32'h22222222, 3, 3, "rd4_a");
      step(0, 1, 0, 32'h4, 0, BUSY,   0, 4, 3, "rd4h_b1");
      step(0, 1, 0, 32'h4, 0, BUSY,   0, 4, 3, "rd4h_b2");
      step(0, 1, 0, 32'h4, 0, ACCESS, 32'h22222222, 4, 3, "rd4h_a");
      step(0, 0, 0, 32'h0, 0, FREE,   0, 5, 3, "idle4");
      // abandon: 0x8 switched to 0xC after one BUSY
      step(0, 0, 1, 32'h8, 32'h55, BUSY,   0, 5, 3, "ab8_b1");
      step(0, 0, 1, 32'hC, 32'h66, BUSY,   0, 5, 3, "abC_b1");
      step(0, 0, 1, 32'hC, 32'h66, BUSY,   0, 5, 3, "abC_b2");
      step(0, 0, 1, 32'hC, 32'h66, ACCESS, 0, 5, 3, "abC_a");
      step(0, 0, 0, 32'h0, 0, FREE, 0, 5, 4, "idle5");
      step(0, 1, 0, 32'h8, 0, BUSY,   0, 5, 4, "rd8_b1");
      step(0, 1, 0, 32'h8, 0, BUSY,   0, 5, 4, "rd8_b2");
      step(0, 1, 0, 32'h8, 0, ACCESS, 0, 5, 4, "rd8_a");
      step(0, 1, 0, 32'hC, 0, BUSY,   0, 6, 4, "rdC_b1");
      step(0, 1, 0, 32'hC, 0, BUSY,   0, 6, 4, "rdC_b2");
      step(0, 1, 0, 32'hC, 0, ACCESS, 32'h66, 6, 4, "rdC_a");
      step(0, 0, 0, 32'h0, 0, FREE, 0, 7, 4, "idle6");
      // errors: both enables, then drop WEN
      step(0, 1, 1, 32'h40, 32'h99, ERROR, 0, 7, 4, "err_rw1");
      step(0, 1, 1, 32'h40, 32'h99, ERROR, 0, 7, 4, "err_rw2");
      step(0, 1, 0, 32'h40, 0, BUSY,   0, 7, 4, "drop_b1");
      step(0, 1, 0, 32'h40, 0, BUSY,   0, 7, 4, "drop_b2");
      step(0, 1, 0, 32'h40, 0, ACCESS, 0, 7, 4, "drop_a");
      // out of range, then last legal word
      step(0, 1, 0, 32'h1000, 0, ERROR, 0, 8, 4, "err_oor1");
      step(0, 1, 0, 32'h1000, 0, ERROR, 0, 8, 4, "err_oor2");
      step(0, 1, 0, 32'hFFC, 0, BUSY,   0, 8, 4, "top_b1");
      step(0, 1, 0, 32'hFFC, 0, BUSY,   0, 8, 4, "top_b2");
      step(0, 1, 0, 32'hFFC, 0, ACCESS, 0, 8, 4, "top_a");
      // out-of-range write must not alias onto word 0
      step(0, 0, 1, 32'h1000, 32'hAA, ERROR, 0, 9, 4, "err_wr");
      step(0, 0, 1, 32'h1000, 32'hAA, ERROR, 0, 9, 4, "err_wr2");
      step(0, 0, 1, 32'h1000, 32'hAA, ERROR, 0, 9, 4, "err_wr3");
      step(0, 1, 0, 32'h0, 0, BUSY,   0, 9, 4, "alias_b1");
      step(0, 1, 0, 32'h0, 0, BUSY,   0, 9, 4, "alias_b2");
      step(0, 1, 0, 32'h0, 0, ACCESS, 32'h11111111, 9, 4, "alias_a");
      step(0, 0, 0, 32'h0, 0, FREE, 0, 10, 4, "idle7");
      // reset during 2nd BUSY of a write of 0x77 to 0x20
      step(0, 0, 1, 32'h20, 32'h77, BUSY, 0, 10, 4, "rm_b1");
      step(1, 0, 1, 32'h20, 32'h77, FREE, 0, 10, 4, "rm_rst1");
      step(1, 0, 1, 32'h20, 32'h77, FREE, 0, 0, 0, "rm_rst2");
      step(0, 0, 1, 32'h20, 32'h77, BUSY,   0, 0, 0, "rm_b1r");
      step(0, 0, 1, 32'h20, 32'h77, BUSY,   0, 0, 0, "rm_b2r");
      step(0, 0, 1, 32'h20, 32'h77, ACCESS, 0, 0, 0, "rm_a");
      // array cleared by reset, then fresh write visible
      step(0, 1, 0, 32'h100, 0, BUSY,   0, 0, 1, "clr_b1");
      step(0, 1, 0, 32'h100, 0, BUSY,   0, 0, 1, "clr_b2");
      step(0, 1, 0, 32'h100, 0, ACCESS, 0, 0, 1, "clr_a");
      step(0, 1, 0, 32'h20, 0, BUSY,   0, 1, 1, "rd20_b1");
      step(0, 1, 0, 32'h20, 0, BUSY,   0, 1, 1, "rd20_b2");
      step(0, 1, 0, 32'h20, 0, ACCESS, 32'h77, 1, 1, "rd20_a");
      step(0, 0, 0, 32'h0, 0, FREE, 0, 2, 1, "idle8");

      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(posedge CLK);
         n++;
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain queue left %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
